// File: rtl/uart_dump.sv
// uart_dump: debug read-back engine. Reads a block of words over the RIB
// master-1 read port and streams each word out of an 8N1 UART transmitter,
// least-significant byte first, with frames packed back-to-back.
module uart_dump #(
  parameter int BAUD_DIV = 434,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [31:0]      base_addr_i,
  input  logic [CNT_W-1:0] word_cnt_i,
  output logic             rib_rreq_o,
  output logic [31:0]      rib_raddr_o,
  input  logic [31:0]      rib_rdata_i,
  input  logic             rib_gnt_i,
  output logic             uart_tx,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  state_t           state_reg, state_next;
  logic [31:0]      addr_reg, addr_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;
  logic [31:0]      word_reg, word_next;
  logic [1:0]       byte_reg, byte_next;
  logic [2:0]       bit_reg, bit_next;
  logic [15:0]      baud_reg, baud_next;
  logic             tx_reg, tx_next;
  logic             baud_end;

  // The two low address bits are deliberately dropped (word alignment).
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^base_addr_i[1:0];

  assign baud_end = (baud_reg == BAUD_LAST);

  // State and datapath registers; reset parks the line high immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg     <= IDLE;
      addr_reg      <= 32'd0;
      remaining_reg <= '0;
      word_reg      <= 32'd0;
      byte_reg      <= 2'd0;
      bit_reg       <= 3'd0;
      baud_reg      <= 16'd0;
      tx_reg        <= 1'b1;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      word_reg      <= word_next;
      byte_reg      <= byte_next;
      bit_reg       <= bit_next;
      baud_reg      <= baud_next;
      tx_reg        <= tx_next;
    end
  end

  // Next-state logic. addr_reg only changes when entering READ, so it doubles
  // as the RIB address and holds its value while no request is pending.
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    word_next      = word_reg;
    byte_next      = byte_reg;
    bit_next       = bit_reg;
    baud_next      = baud_reg;
    tx_next        = 1'b1;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          remaining_next = word_cnt_i;
          baud_next      = 16'd0;
          if (word_cnt_i == '0) begin
            state_next = DONE;
          end else begin
            addr_next  = {base_addr_i[31:2], 2'b00};
            state_next = READ;
          end
        end
      end
      READ: begin
        if (rib_gnt_i) begin
          word_next  = rib_rdata_i;
          byte_next  = 2'd0;
          bit_next   = 3'd0;
          baud_next  = 16'd0;
          state_next = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_next  = 16'd0;
          bit_next   = 3'd0;
          state_next = DATA;
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_next = 16'd0;
          if (bit_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_next = 16'd0;
          if (byte_reg != 2'd3) begin
            byte_next  = byte_reg + 2'd1;
            state_next = START;
          end else if (remaining_reg > CNT_W'(1)) begin
            remaining_next = remaining_reg - CNT_W'(1);
            addr_next      = addr_reg + 32'd4;
            state_next     = READ;
          end else begin
            state_next = DONE;
          end
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Line level follows the state being entered so uart_tx is a clean flop.
    if (state_next == START) begin
      tx_next = 1'b0;
    end else if (state_next == DATA) begin
      tx_next = word_next[{byte_next, bit_next}];
    end
  end

  assign uart_tx     = tx_reg;
  assign rib_rreq_o  = (state_reg == READ);
  assign rib_raddr_o = addr_reg;
  assign busy_o      = (state_reg != IDLE);
  assign done_o      = (state_reg == DONE);

endmodule
